// File: rtl/nn_cfg_pkg.sv
// Shared types for the layer-configuration broadcast bus and its loader FSM.
// Pure declarations; no timing or flow control of its own.
package nn_cfg_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WEIGHT = 2'd1,
    BIAS   = 2'd2,
    FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic             weightValid;
    logic             biasValid;
    logic [BUS_W-1:0] weightValue;
    logic [BUS_W-1:0] biasValue;
    logic [BUS_W-1:0] layer;
    logic [BUS_W-1:0] neuron;
  } bus_t;

  function automatic logic [BUS_W-1:0] neuron_tag(input int unsigned first,
                                                  input logic [BUS_W-1:0] idx);
    return BUS_W'(first) + idx;
  endfunction

endpackage

// File: rtl/nn_weight_loader.sv
// Sequences an upstream word stream into per-neuron weight/bias bursts on the config bus.
// Latency: one cycle from upstream transfer to bus output; done one cycle after the last bias.
// Backpressure: none from neurons; s_ready is high only while in WEIGHT/BIAS, stalls come from s_valid.
module nn_weight_loader
  import nn_cfg_pkg::*;
#(
  parameter int dataWidth     = 16,
  parameter int cntWidth      = 16,
  parameter int firstNeuronNo = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUS_W-1:0]    layer_num,
  input  logic [cntWidth-1:0] num_neurons,
  input  logic [cntWidth-1:0] num_weights,
  input  logic [BUS_W-1:0]    s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                weightValid,
  output logic                biasValid,
  output logic [BUS_W-1:0]    weightValue,
  output logic [BUS_W-1:0]    biasValue,
  output logic [BUS_W-1:0]    config_layer_num,
  output logic [BUS_W-1:0]    config_neuron_num,
  output logic                busy,
  output logic                done
);

  if (dataWidth < 1 || dataWidth > BUS_W) begin : g_bad_width
    $error("nn_weight_loader: dataWidth must fit in the bus word");
  end

  state_e              state;
  logic [cntWidth-1:0] wcnt;
  logic [cntWidth-1:0] ncnt;
  logic [cntWidth-1:0] nn_q;
  logic [cntWidth-1:0] nw_q;
  logic [BUS_W-1:0]    layer_q;
  bus_t                bus;
  logic                done_q;
  logic                xfer;
  logic                last_w;
  logic                last_n;

  assign s_ready = (state == WEIGHT) || (state == BIAS);
  assign busy    = s_ready;
  assign xfer    = s_valid && s_ready;
  assign last_w  = (wcnt == nw_q - cntWidth'(1));
  assign last_n  = (ncnt == nn_q - cntWidth'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      ncnt    <= '0;
      nn_q    <= '0;
      nw_q    <= '0;
      layer_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            layer_q <= layer_num;
            nn_q    <= num_neurons;
            nw_q    <= num_weights;
            wcnt    <= '0;
            ncnt    <= '0;
            if (num_neurons == '0)      state <= FINISH;
            else if (num_weights == '0) state <= BIAS;
            else                        state <= WEIGHT;
          end
        end
        WEIGHT: begin
          if (xfer) begin
            wcnt <= wcnt + cntWidth'(1);
            if (last_w) state <= BIAS;
          end
        end
        BIAS: begin
          if (xfer) begin
            wcnt <= '0;
            ncnt <= ncnt + cntWidth'(1);
            // Zero-weight layers stay in BIAS so every word becomes a bias.
            if (last_n)            state <= FINISH;
            else if (nw_q != '0)   state <= WEIGHT;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Values and tags only move on a transfer, so neurons see stable tags between words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus    <= '0;
      done_q <= 1'b0;
    end else begin
      bus.weightValid <= xfer && (state == WEIGHT);
      bus.biasValid   <= xfer && (state == BIAS);
      if (xfer) begin
        bus.layer  <= layer_q;
        bus.neuron <= neuron_tag(firstNeuronNo, BUS_W'(ncnt));
        if (state == WEIGHT) bus.weightValue <= s_data;
        else                 bus.biasValue   <= s_data;
      end
      done_q <= (state == FINISH);
    end
  end

  assign weightValid       = bus.weightValid;
  assign biasValid         = bus.biasValid;
  assign weightValue       = bus.weightValue;
  assign biasValue         = bus.biasValue;
  assign config_layer_num  = bus.layer;
  assign config_neuron_num = bus.neuron;
  assign done              = done_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Bench for nn_weight_loader: two instances (first neuron 0 and 26) driven in lockstep
// and compared every cycle against a queue-based model of the expected word slots.
module tb_nn_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] layer_num = '0;
  logic [15:0] num_neurons = '0;
  logic [15:0] num_weights = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;

  logic        s_ready[2], weightValid[2], biasValid[2], busy[2], done[2];
  logic [31:0] weightValue[2], biasValue[2], cfg_layer[2], cfg_neuron[2];

  always #5 clk = ~clk;

  nn_weight_loader #(.dataWidth(16), .cntWidth(16), .firstNeuronNo(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .layer_num(layer_num),
    .num_neurons(num_neurons), .num_weights(num_weights),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[0]),
    .weightValid(weightValid[0]), .biasValid(biasValid[0]),
    .weightValue(weightValue[0]), .biasValue(biasValue[0]),
    .config_layer_num(cfg_layer[0]), .config_neuron_num(cfg_neuron[0]),
    .busy(busy[0]), .done(done[0]));

  nn_weight_loader #(.dataWidth(16), .cntWidth(16), .firstNeuronNo(26)) u_dut26 (
    .clk(clk), .rst(rst), .start(start), .layer_num(layer_num),
    .num_neurons(num_neurons), .num_weights(num_weights),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[1]),
    .weightValid(weightValid[1]), .biasValid(biasValid[1]),
    .weightValue(weightValue[1]), .biasValue(biasValue[1]),
    .config_layer_num(cfg_layer[1]), .config_neuron_num(cfg_neuron[1]),
    .busy(busy[1]), .done(done[1]));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a queue of word slots (weight/bias, neuron index) filled when a command is accepted.
  typedef struct {
    bit          bias;
    int unsigned n;
  } slot_t;

  slot_t       q[$];
  bit          m_active = 0, m_fin = 0, m_done = 0;
  logic [31:0] m_layer = '0;
  bit          e_wv = 0, e_bv = 0, e_tagged = 0;
  logic [31:0] e_wval = '0, e_bval = '0, e_layer = '0;
  int unsigned e_n = 0;
  int          xfer_cnt = 0;
  int          done_seen = 0;
  int          w26 = 0;
  int unsigned off[2] = '{0, 26};

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.weightValid", i), 32'(weightValid[i]), 32'(e_wv));
      chk($sformatf("d%0d.biasValid", i),   32'(biasValid[i]),   32'(e_bv));
      chk($sformatf("d%0d.weightValue", i), weightValue[i],      e_wval);
      chk($sformatf("d%0d.biasValue", i),   biasValue[i],        e_bval);
      chk($sformatf("d%0d.layer", i),       cfg_layer[i],        e_layer);
      chk($sformatf("d%0d.neuron", i),      cfg_neuron[i],       e_tagged ? off[i] + e_n : 32'd0);
      chk($sformatf("d%0d.busy", i),        32'(busy[i]),        32'(m_active));
      chk($sformatf("d%0d.s_ready", i),     32'(s_ready[i]),     32'(m_active));
      chk($sformatf("d%0d.done", i),        32'(done[i]),        32'(m_done));
    end
  endtask

  // One clock: predict from the stable inputs, take the edge, then compare.
  task automatic step();
    bit          n_active = m_active;
    bit          n_fin = 0;
    bit          n_wv = 0, n_bv = 0;
    slot_t       s;
    if (m_active && s_valid) begin
      s = q.pop_front();
      n_wv = !s.bias;
      n_bv = s.bias;
      if (s.bias) e_bval = s_data;
      else        e_wval = s_data;
      e_layer  = m_layer;
      e_n      = s.n;
      e_tagged = 1;
      xfer_cnt++;
      if (q.size() == 0) begin
        n_active = 0;
        n_fin    = 1;
      end
    end
    if (!m_active && !m_fin && start) begin
      m_layer = layer_num;
      for (int n = 0; n < int'(num_neurons); n++) begin
        for (int w = 0; w < int'(num_weights); w++) q.push_back('{bias: 0, n: n});
        q.push_back('{bias: 1, n: n});
      end
      if (q.size() == 0) n_fin = 1;
      else               n_active = 1;
    end
    @(posedge clk);
    #1;
    m_done   = m_fin;
    m_fin    = n_fin;
    m_active = n_active;
    e_wv     = n_wv;
    e_bv     = n_bv;
    cmp_all();
    if (done[0]) done_seen++;
    if (weightValid[1] && cfg_neuron[1] == 32'd26 && cfg_layer[1] == 32'd1) w26++;
  endtask

  task automatic do_reset();
    s_valid = 0;
    start   = 0;
    #2;
    rst = 0;
    #1;
    q.delete();
    m_active = 0; m_fin = 0; m_done = 0;
    e_wv = 0; e_bv = 0; e_tagged = 0;
    e_wval = '0; e_bval = '0; e_layer = '0; e_n = 0;
    cmp_all();
    @(posedge clk);
    #3;
    rst = 1;
  endtask

  function automatic bit pick_valid(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return ($urandom_range(0, 9) < 6);
    endcase
  endfunction

  // vmode: 0 continuous, 1 stall pattern 1,0,0,1, 2 random; busy_at/rst_at < 0 disable them.
  task automatic run_layer(input logic [31:0] lay, input int nn, input int nw, input int vmode,
                           input bit seq, input int busy_at, input int rst_at);
    int budget = (nn * (nw + 1) + 4) * 8 + 20;
    int x0 = xfer_cnt;
    int cyc = 0;
    int d0 = done_seen;
    layer_num   = lay;
    num_neurons = 16'(nn);
    num_weights = 16'(nw);
    start   = 1;
    s_valid = 1;
    s_data  = seq ? 32'(xfer_cnt - x0 + 1) : $urandom;
    step();
    start = 0;
    while (!m_done && cyc < budget) begin
      s_valid = pick_valid(vmode, cyc);
      s_data  = seq ? 32'(xfer_cnt - x0 + 1) : $urandom;
      if (cyc == busy_at) begin
        start     = 1;
        layer_num = 32'd7;
      end else begin
        start = 0;
      end
      step();
      cyc++;
      if (rst_at >= 0 && xfer_cnt - x0 == rst_at) begin
        do_reset();
        return;
      end
    end
    chk("done_reached", 32'(m_done), 32'd1);
    s_valid = 0;
    start   = 0;
    step();
    chk("done_count", 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    #12;
    cmp_all();
    rst = 1;
    // Words offered while idle must not be taken.
    s_valid = 1;
    s_data  = 32'hdead_beef;
    step();
    step();

    run_layer(32'd1, 2, 3, 0, 1, -1, -1);
    run_layer(32'd1, 2, 3, 1, 1, -1, -1);
    run_layer(32'd2, 0, 5, 0, 1, -1, -1);
    run_layer(32'd3, 3, 0, 0, 1, -1, -1);
    run_layer(32'd1, 2, 3, 2, 1, 3, -1);
    run_layer(32'd1, 2, 3, 0, 1, -1, 5);
    run_layer(32'd1, 2, 3, 0, 1, -1, -1);

    w26 = 0;
    run_layer(32'd1, 1, 784, 0, 0, -1, -1);
    chk("neuron26_weights", 32'(w26), 32'd784);

    for (int t = 0; t < 12; t++)
      run_layer($urandom, $urandom_range(0, 4), $urandom_range(0, 5), 2, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
